// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial sequence detector: MSB-first pattern match with KMP
// failure transitions, optional overlap, sample enable and a saturating match counter.
module seq_detect_moore_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8,
   parameter int                 SW      = $clog2(PAT_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inp,
   input  logic             en,
   input  logic             cnt_clr,
   output logic             outp,
   output logic [SW-1:0]    state,
   output logic [CNT_W-1:0] match_cnt
);

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $error("seq_detect_moore_param: PAT_LEN must lie in 2..16");
   end
   if (CNT_W < 1) begin : g_bad_cnt
      $error("seq_detect_moore_param: CNT_W must be at least 1");
   end
   if (SW != $clog2(PAT_LEN + 1)) begin : g_bad_sw
      $error("seq_detect_moore_param: SW is derived and must not be overridden");
   end

   typedef enum logic [SW-1:0] {
      S_IDLE  = SW'(0),
      S_MATCH = SW'(PAT_LEN)
   } state_t;

   // Pattern bit by arrival order: position 0 is the first bit received.
   function automatic logic pat_bit(input int pos);
      logic [PAT_LEN-1:0] sh;
      sh = PATTERN >> (PAT_LEN - 1 - pos);
      return sh[0];
   endfunction

   // Longest j <= k+1 such that the last j bits of (prefix_k, b) equal prefix_j.
   function automatic int kmp_next(input int k, input logic b);
      int   best;
      int   idx;
      logic ok;
      logic sb;
      best = 0;
      for (int j = 1; j <= PAT_LEN; j++) begin
         ok = (j <= k + 1);
         for (int m = 0; m < PAT_LEN; m++) begin
            if (ok && m < j) begin
               idx = k + 1 - j + m;
               sb  = (idx == k) ? b : pat_bit(idx);
               if (sb != pat_bit(m)) ok = 1'b0;
            end
         end
         if (ok) best = j;
      end
      return best;
   endfunction

   // Longest proper prefix of the pattern that is also a suffix.
   function automatic int border_len();
      int   f;
      logic ok;
      f = 0;
      for (int j = 1; j < PAT_LEN; j++) begin
         ok = 1'b1;
         for (int m = 0; m < PAT_LEN; m++) begin
            if (m < j && pat_bit(m) != pat_bit(PAT_LEN - j + m)) ok = 1'b0;
         end
         if (ok) f = j;
      end
      return f;
   endfunction

   localparam int RESTART = OVERLAP ? border_len() : 0;

   logic [PAT_LEN-1:0][SW-1:0] nxt0_s;
   logic [PAT_LEN-1:0][SW-1:0] nxt1_s;

   for (genvar k = 0; k < PAT_LEN; k++) begin : g_tbl
      localparam int N0 = kmp_next(k, 1'b0);
      localparam int N1 = kmp_next(k, 1'b1);
      assign nxt0_s[k] = SW'(N0);
      assign nxt1_s[k] = SW'(N1);
   end

   state_t           state_r;
   logic             outp_r;
   logic [CNT_W-1:0] cnt_r;
   logic [SW-1:0]    eff_s;
   logic [SW-1:0]    next_s;
   logic             hit_s;
   logic [CNT_W-1:0] cnt_base_s;
   logic [CNT_W-1:0] cnt_next_s;

   // Next-state lookup from the effective state, plus clear-then-count counter update.
   always_comb begin
      eff_s      = state_r;
      next_s     = state_r;
      hit_s      = 1'b0;
      cnt_base_s = cnt_r;
      cnt_next_s = cnt_r;
      if (state_r == S_MATCH) begin
         eff_s = SW'(RESTART);
      end else begin
         eff_s = state_r;
      end
      if (en) begin
         next_s = {SW{1'b0}};
         for (int k = 0; k < PAT_LEN; k++) begin
            next_s = (eff_s == SW'(k)) ? (inp ? nxt1_s[k] : nxt0_s[k]) : next_s;
         end
      end else begin
         next_s = state_r;
      end
      hit_s      = en && (next_s == S_MATCH);
      cnt_base_s = cnt_clr ? {CNT_W{1'b0}} : cnt_r;
      if (hit_s && (cnt_base_s != {CNT_W{1'b1}})) begin
         cnt_next_s = cnt_base_s + CNT_W'(1);
      end else begin
         cnt_next_s = cnt_base_s;
      end
   end

   // State, detect flag and counter registers; detect flag mirrors state == PAT_LEN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         outp_r  <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_t'(next_s);
         outp_r  <= (next_s == S_MATCH);
         cnt_r   <= cnt_next_s;
      end
   end

   assign outp      = outp_r;
   assign state     = state_r;
   assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed bench for seq_detect_moore_param: five parameter variants share one
// input stream; each step checks the relevant variant against hand-computed values.
module tb_seq_detect_moore_param;

   logic clk = 1'b0;
   logic rst, inp, en, cnt_clr;

   logic       outp_a, outp_b, outp_c, outp_d, outp_e;
   logic [2:0] state_a, state_b, state_c, state_d, state_e;
   logic [7:0] cnt_a, cnt_b, cnt_d, cnt_e;
   logic [1:0] cnt_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_detect_moore_param dut (
      .clk(clk), .rst(rst), .inp(inp), .en(en), .cnt_clr(cnt_clr),
      .outp(outp_a), .state(state_a), .match_cnt(cnt_a));

   seq_detect_moore_param #(.OVERLAP(1'b0)) dut_no (
      .clk(clk), .rst(rst), .inp(inp), .en(en), .cnt_clr(cnt_clr),
      .outp(outp_b), .state(state_b), .match_cnt(cnt_b));

   seq_detect_moore_param #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .inp(inp), .en(en), .cnt_clr(cnt_clr),
      .outp(outp_c), .state(state_c), .match_cnt(cnt_c));

   seq_detect_moore_param #(.PATTERN(4'b1111)) dut_ones (
      .clk(clk), .rst(rst), .inp(inp), .en(en), .cnt_clr(cnt_clr),
      .outp(outp_d), .state(state_d), .match_cnt(cnt_d));

   seq_detect_moore_param #(.PATTERN(4'b1111), .OVERLAP(1'b0)) dut_ones_no (
      .clk(clk), .rst(rst), .inp(inp), .en(en), .cnt_clr(cnt_clr),
      .outp(outp_e), .state(state_e), .match_cnt(cnt_e));

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One enabled bit; returns 1 time unit after the sampling edge.
   task automatic send(input logic b);
      inp = b;
      en  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One disabled cycle with inp driven to b.
   task automatic idle(input logic b);
      inp = b;
      en  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en = 1'b0;
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; inp = 1'b0; en = 1'b0; cnt_clr = 1'b0;

      // Reset held with toggling data
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         inp = ~inp;
         en  = 1'b1;
      end
      #1;
      chk("rst_state", int'(state_a), 0);
      chk("rst_outp", int'(outp_a), 0);
      chk("rst_cnt", int'(cnt_a), 0);
      #1 rst = 1'b0;
      send(1'b1); send(1'b0); send(1'b1);
      chk("pre_async_state", int'(state_a), 3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_state", int'(state_a), 0);
      #1 rst = 1'b0;
      send(1'b1); send(1'b0); send(1'b1); send(1'b1);
      chk("after_rst_outp", int'(outp_a), 1);
      chk("after_rst_cnt", int'(cnt_a), 1);

      // Basic detect
      do_reset();
      send(1'b1); chk("basic_s1", int'(state_a), 1);
      send(1'b0); chk("basic_s2", int'(state_a), 2);
      send(1'b1); chk("basic_s3", int'(state_a), 3);
      chk("basic_outp_pre", int'(outp_a), 0);
      send(1'b1); chk("basic_s4", int'(state_a), 4);
      chk("basic_outp", int'(outp_a), 1);
      chk("basic_cnt", int'(cnt_a), 1);
      send(1'b0);
      chk("basic_outp_drop", int'(outp_a), 0);
      chk("basic_post_state", int'(state_a), 2);

      // Overlap vs non-overlap on 1011011
      do_reset();
      send(1'b1); send(1'b0); send(1'b1); send(1'b1);
      chk("ovl_b4_outp", int'(outp_a), 1);
      chk("novl_b4_outp", int'(outp_b), 1);
      send(1'b0);
      chk("ovl_b5_state", int'(state_a), 2);
      chk("novl_b5_state", int'(state_b), 0);
      send(1'b1); send(1'b1);
      chk("ovl_b7_outp", int'(outp_a), 1);
      chk("ovl_b7_cnt", int'(cnt_a), 2);
      chk("novl_b7_outp", int'(outp_b), 0);
      chk("novl_b7_state", int'(state_b), 1);
      chk("novl_b7_cnt", int'(cnt_b), 1);

      // Enable gaps
      do_reset();
      send(1'b1); send(1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(i[0]);
         chk("gap_state", int'(state_a), 2);
      end
      send(1'b1); send(1'b1);
      chk("gap_outp", int'(outp_a), 1);
      chk("gap_cnt", int'(cnt_a), 1);
      idle(1'b1); idle(1'b0);
      chk("hold_outp", int'(outp_a), 1);
      chk("hold_state", int'(state_a), 4);
      chk("hold_cnt", int'(cnt_a), 1);

      // Saturating counter, CNT_W=2
      do_reset();
      send(1'b1); send(1'b0); send(1'b1); send(1'b1);
      chk("sat_cnt_1", int'(cnt_c), 1);
      for (int i = 2; i <= 6; i++) begin
         send(1'b0); send(1'b1); send(1'b1);
         chk("sat_cnt", int'(cnt_c), (i > 3) ? 3 : i);
      end
      chk("wide_cnt_6", int'(cnt_a), 6);
      send(1'b0); send(1'b1);
      cnt_clr = 1'b1;
      send(1'b1);
      cnt_clr = 1'b0;
      chk("clr_match_cnt", int'(cnt_c), 1);
      chk("clr_match_outp", int'(outp_c), 1);
      cnt_clr = 1'b1;
      idle(1'b0);
      cnt_clr = 1'b0;
      chk("clr_only_cnt", int'(cnt_c), 0);
      chk("clr_only_state", int'(state_c), 4);

      // All-ones pattern, overlap and non-overlap
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send(1'b1);
         chk("ones_ovl_outp", int'(outp_d), (i >= 3) ? 1 : 0);
         chk("ones_novl_outp", int'(outp_e), (i == 3) ? 1 : 0);
      end
      chk("ones_ovl_cnt", int'(cnt_d), 3);
      chk("ones_novl_cnt", int'(cnt_e), 1);
      chk("ones_novl_state", int'(state_e), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_detect_moore_param.md
# seq_detect_moore_param

Parametrised Moore-style serial sequence detector, successor to the fixed 2-bit-state Moore detector in the session designs. It compares a serial bit stream, MSB first, against a compile-time pattern of configurable length. It supports overlapping or non-overlapping detection, gates sampling with an enable, and keeps a saturating match counter. It sits directly on a serial input line and is driven and observed through the `clk`/`rst`/`inp`/`outp`/`state` style of interface used across the session blocks.

## Interface
- `PAT_LEN`, 4: pattern length in bits, 2..16.
- `PATTERN`, 4'b1011: pattern bits, `PAT_LEN` wide; bit `PAT_LEN-1` is the first bit received.
- `OVERLAP`, 1: 1 = overlapping detection, 0 = restart after each match.
- `CNT_W`, 8: match counter width, at least 1.
- `SW`, `$clog2(PAT_LEN+1)`: state width; derived, not overridden.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `inp`, in, 1: serial data bit.
- `en`, in, 1: sample enable; `inp` is consumed only on edges where `en`=1.
- `cnt_clr`, in, 1: synchronous clear of `match_cnt`.
- `outp`, out, 1: detect flag; high while `state`==`PAT_LEN`.
- `state`, out, `SW`: current state = number of pattern bits currently matched (0..`PAT_LEN`).
- `match_cnt`, out, `CNT_W`: number of detections since reset or clear; saturating.

## Operation
- States S0..S`PAT_LEN`. Sk means the last k sampled bits equal the first k bits of `PATTERN`, and k is the longest such prefix.
- Transitions are evaluated only when `en`=1. When `en`=0, `state` and `match_cnt` hold.
- Next state from Sk (k<`PAT_LEN`) on bit b: take the longest j ≤ k+1 such that the last j bits of (prefix_k, b) equal prefix_j. This is a KMP failure transition, computed combinationally from the parameters.
- From S`PAT_LEN`:
  - `OVERLAP`=1: evaluate as from Sf, where f = length of the longest proper prefix of `PATTERN` that is also a suffix.
  - `OVERLAP`=0: evaluate as from S0.
- `outp` = (`state`==`PAT_LEN`). Pure Moore: it is a function of the registered state only and does not depend on `inp` combinationally.
- `match_cnt` increments by 1 on every edge with `en`=1 whose next state is S`PAT_LEN`. This includes S`PAT_LEN`→S`PAT_LEN`.
- `match_cnt` saturates at 2^`CNT_W`−1 and never wraps.
- `cnt_clr`=1 at an edge loads 0. If a match occurs on the same edge, it loads 1 (clear then count).
- `cnt_clr` does not affect `state`.
- `PAT_LEN`=1 is illegal; elaboration must fail on `PAT_LEN`<2 or `PAT_LEN`>16.

## Timing
- Reset, asynchronous on `rst` high: `state`=0, `outp`=0, `match_cnt`=0, immediately and without needing a clock.
- Reset asserted mid-sequence discards the partial match. The first enabled edge after deassertion is evaluated from S0.
- Latency: `outp` rises in the cycle following the rising edge that samples the last pattern bit. Same cycle as the `match_cnt` update.
- `outp` stays high for exactly one cycle per match while `en`=1.
  - It stays high for consecutive cycles only when each sampled bit completes a new overlapping match, e.g. a pattern of all ones.
  - It stays high for multiple cycles if `en` drops while in S`PAT_LEN`. A held detect is not re-counted.
- `inp` and `en` must be stable around the `clk` rising edge. There is no internal synchronizer.

## Test plan
1. Reset: hold `rst`=1 for 100 ns with `inp`=1 toggling → `state`=0, `outp`=0, `match_cnt`=0. Feed 1,0,1, then pulse `rst` between clock edges → `state` returns to 0 asynchronously. A following 1,0,1,1 gives exactly one detect.
2. Basic detect (defaults): after reset, enabled bits 1,0,1,1 → `state` sequence 1,2,3,4. `outp`=1 for exactly one cycle after the 4th edge. `match_cnt`=1.
3. Overlap: bits 1,0,1,1,0,1,1 with `OVERLAP`=1 → `outp` pulses after bits 4 and 7, `match_cnt`=2; state after bit 4 re-evaluates from S1, giving S2 on the 0. Same stream with `OVERLAP`=0 → one pulse, `match_cnt`=1.
4. Enable gaps: bits 1,0 then `en`=0 for 3 cycles with `inp` toggling, then 1,1 → single detect, `state` frozen at 2 during the gap. Drop `en` while in S4 → `outp` held high, `match_cnt` unchanged.
5. Counter: `CNT_W`=2, six overlapping matches → `match_cnt` goes 1,2,3,3,3,3. Assert `cnt_clr` on the edge of a match → `match_cnt`=1. Assert `cnt_clr` alone → 0, `state` unchanged.
6. All-ones pattern: `PATTERN`=4'b1111, `OVERLAP`=1, six 1s → `outp` high for 3 consecutive cycles, `match_cnt`=3. With `OVERLAP`=0 → `outp` high for 1 cycle, `match_cnt`=1, `state` after bit 6 = 2.
